// File: rtl/dtc_vote_pkg.sv
// Shared types and defaults for the dtc window-vote stage and the classifier wrappers.
// The majority helper is what turns the per-bit ones counts into the voted code.
package dtc_vote_pkg;

    localparam int DTC_W   = 8;
    localparam int DTC_WIN = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } vote_state_e;

    // Strict majority: a bit is set only when more than half the samples had it set.
    // Arguments are zero-extended counts; doubling happens in one extra bit, so ties give 0.
    function automatic logic majority(input logic [15:0] ones, input logic [15:0] n);
        return {ones, 1'b0} > {1'b0, n};
    endfunction

endpackage

// File: rtl/dtc_bit_counter.sv
// One per-bit ones counter of the window vote.
// It exposes its next-state value so the vote can include the sample accepted in the closing cycle.
module dtc_bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_next_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d      = cnt_q + CNT_W'(inc_i);
    assign cnt_next_o = cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dtc_window_vote.sv
// Windowed per-bit majority vote over classifier codes, with valid/ready on both sides.
// A window closes when it fills or on flush; the result is held until downstream takes it.
module dtc_window_vote
    import dtc_vote_pkg::*;
#(
    parameter  int W     = DTC_W,
    parameter  int WIN   = DTC_WIN,
    localparam int CNT_W = $clog2(WIN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W-1:0]     in_data_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W-1:0]     out_data_o,
    output logic [CNT_W-1:0] out_count_o
);

    vote_state_e      state_q;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] n_d;
    logic             out_valid_q;
    logic [W-1:0]     out_data_q;
    logic [CNT_W-1:0] out_count_q;

    logic             accept;
    logic             close_win;
    logic             release_out;
    logic [W-1:0]     inc;
    logic [W-1:0]     vote_d;
    logic [CNT_W-1:0] ones_d [W];

    assign in_ready_o  = (state_q == ACCUM);
    assign accept      = in_ready_o && in_valid_i;
    assign n_d         = n_q + CNT_W'(accept);
    // An empty-window flush is dropped: n_d counts the sample accepted this same cycle.
    assign close_win   = in_ready_o &&
                         ((accept && (n_d == CNT_W'(WIN))) || (flush_i && (n_d != '0)));
    assign release_out = (state_q == HOLD) && out_ready_i;
    assign inc         = in_data_i & {W{accept}};

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            dtc_bit_counter #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .clk       (clk),
                .rst_n     (rst_n),
                .clr_i     (release_out),
                .inc_i     (inc[gi]),
                .cnt_next_o(ones_d[gi])
            );

            assign vote_d[gi] = majority(16'(ones_d[gi]), 16'(n_d));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            n_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    n_q <= n_d;
                    if (close_win) begin
                        state_q     <= HOLD;
                        out_valid_q <= 1'b1;
                        out_data_q  <= vote_d;
                        out_count_q <= n_d;
                    end
                end
                HOLD: begin
                    if (out_ready_i) begin
                        state_q     <= ACCUM;
                        out_valid_q <= 1'b0;
                        n_q         <= '0;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_count_o = out_count_q;

endmodule

// File: tb/tb_dtc_window_vote.sv
// Directed and randomized checks of the window vote stage at W=8, WIN=8.
module tb_dtc_window_vote;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [3:0] out_count;

    int checks = 0;
    int errors = 0;

    dtc_window_vote #(.W(8), .WIN(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .flush_i    (flush),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_count_o(out_count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic f);
        in_valid = 1'b1;
        in_data  = d;
        flush    = f;
        cyc();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h c=%0d want v=0 d=00 c=0", out_valid, out_data, out_count);
        end
        rst_n = 1'b1;
        cyc();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        end
        $display("reset: rdy=%b v=%b", in_ready, out_valid);
    endtask

    task automatic test_full_window();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) push(8'h00, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hFF || out_count !== 4'd8 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_window got v=%b d=%h c=%0d rdy=%b want v=1 d=ff c=8 rdy=0",
                     out_valid, out_data, out_count, in_ready);
        end
        $display("full window: d=%h c=%0d", out_data, out_count);
        cyc();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'hFF) begin
            errors++;
            $display("FAIL full_window_release got v=%b rdy=%b d=%h want v=0 rdy=1 d=ff",
                     out_valid, in_ready, out_data);
        end
    endtask

    task automatic test_tie();
        for (int i = 0; i < 4; i++) push(8'hA5, 1'b0);
        for (int i = 0; i < 4; i++) push(8'h5A, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h00 || out_count !== 4'd8) begin
            errors++;
            $display("FAIL tie got v=%b d=%h c=%0d want v=1 d=00 c=8", out_valid, out_data, out_count);
        end
        $display("tie window: d=%h c=%0d", out_data, out_count);
        cyc();
    endtask

    task automatic test_flush();
        push(8'h0F, 1'b0);
        push(8'h0F, 1'b0);
        push(8'hF0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h0F || out_count !== 4'd3) begin
            errors++;
            $display("FAIL early_flush got v=%b d=%h c=%0d want v=1 d=0f c=3", out_valid, out_data, out_count);
        end
        $display("early flush: d=%h c=%0d", out_data, out_count);
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        cyc();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL empty_flush got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        $display("empty flush: v=%b", out_valid);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h3C, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
            flush    = 1'b1;
            cyc();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h3C || out_count !== 4'd8 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold cyc=%0d got v=%b d=%h c=%0d rdy=%b want v=1 d=3c c=8 rdy=0",
                         i, out_valid, out_data, out_count, in_ready);
            end
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        cyc();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        $display("backpressure window: d=3c released");
        // A lone sample proves nothing presented during the hold was counted.
        push(8'h01, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h01 || out_count !== 4'd1) begin
            errors++;
            $display("FAIL backpressure_no_leak got v=%b d=%h c=%0d want v=1 d=01 c=1",
                     out_valid, out_data, out_count);
        end
        cyc();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'hFF, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid got v=%b d=%h c=%0d want v=0 d=00 c=0", out_valid, out_data, out_count);
        end
        #2 rst_n = 1'b1;
        cyc();
        for (int i = 0; i < 8; i++) push(8'h81, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h81 || out_count !== 4'd8) begin
            errors++;
            $display("FAIL reset_mid_window got v=%b d=%h c=%0d want v=1 d=81 c=8", out_valid, out_data, out_count);
        end
        $display("after mid reset: d=%h c=%0d", out_data, out_count);
        cyc();
        // Reset while holding a result must drop it.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h81, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold got v=%b rdy=%b c=%0d want v=0 rdy=1 c=0", out_valid, in_ready, out_count);
        end
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        cyc();
    endtask

    task automatic test_random();
        int m_state = 0;
        int m_n = 0;
        int m_ones[8];
        logic       m_valid = 1'b0;
        logic [7:0] m_data = '0;
        int m_count = 0;
        int accepted = 0;
        int dut_sum = 0;
        int drain = 0;
        int cycles = 0;
        logic held = 1'b0;
        for (int i = 0; i < 8; i++) m_ones[i] = 0;
        while (drain < 4 && cycles < 20000) begin
            cycles++;
            if (accepted >= 1000) begin
                in_valid  = 1'b0;
                flush     = 1'b1;
                out_ready = 1'b1;
                drain++;
            end else begin
                if (!held) begin
                    in_valid = ($urandom_range(0, 9) < 6);
                    in_data  = 8'($urandom);
                end
                flush     = ($urandom_range(0, 9) == 0);
                out_ready = ($urandom_range(0, 1) == 1);
            end
            checks++;
            if (in_ready !== (m_state == 0)) begin
                errors++;
                $display("FAIL rand_ready cyc=%0d got %b want %b", cycles, in_ready, (m_state == 0));
            end
            if (out_valid && out_ready) dut_sum += int'(out_count);
            if (m_state == 0) begin
                int nn;
                logic acc;
                acc = in_valid;
                nn  = m_n + (acc ? 1 : 0);
                for (int i = 0; i < 8; i++) m_ones[i] += (acc && in_data[i]) ? 1 : 0;
                if (acc) accepted++;
                held = in_valid && !acc;
                m_n = nn;
                if ((acc && nn == 8) || (flush && nn > 0)) begin
                    for (int i = 0; i < 8; i++) m_data[i] = (2 * m_ones[i] > nn);
                    m_count = nn;
                    m_valid = 1'b1;
                    m_state = 1;
                end
            end else begin
                held = in_valid;
                if (out_ready) begin
                    m_valid = 1'b0;
                    m_state = 0;
                    m_n = 0;
                    for (int i = 0; i < 8; i++) m_ones[i] = 0;
                end
            end
            cyc();
            checks++;
            if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_count !== 4'(m_count)))) begin
                errors++;
                $display("FAIL rand_out cyc=%0d got v=%b d=%h c=%0d want v=%b d=%h c=%0d",
                         cycles, out_valid, out_data, out_count, m_valid, m_data, m_count);
            end
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        checks++;
        if (drain < 4) begin
            errors++;
            $display("FAIL rand_budget got accepted=%0d want 1000 within budget", accepted);
        end
        checks++;
        if (dut_sum != accepted) begin
            errors++;
            $display("FAIL rand_sum got out_count_sum=%0d want accepted=%0d", dut_sum, accepted);
        end
        $display("random: accepted=%0d out_count_sum=%0d", accepted, dut_sum);
    endtask

    initial begin
        test_reset();
        test_full_window();
        test_tie();
        test_flush();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
